// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch-compare stalls and redirect flushes.
// Optional statistics counters are enabled by defining HAZARD_CTRL_STATS_EN.
module hazard_ctrl #(
    parameter int unsigned REG_W        = 5,
    parameter int unsigned LOAD_LAT     = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_rs_used_i,
    input  logic             id_rt_used_i,
    input  logic             id_branch_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             ex_load_i,
    input  logic             ex_regwrite_i,
    input  logic             jump_i,
    input  logic             branch_taken_i,
    output logic             stall_o,
    output logic [1:0]       flush_o,
    output logic             pc_hazard_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [1:0] FLUSH_HOLD   = 2'b00;
    localparam logic [1:0] FLUSH_SQUASH = 2'b01;
    localparam logic [1:0] FLUSH_NEXT   = 2'b10;
    localparam logic [1:0] FCNT_RELOAD  = 2'(FLUSH_CYCLES - 1);

    logic       rs_cand, rt_cand;
    logic       ex_load_hit, dl_hit, load_hazard, branch_hazard, hazard, redirect;
    logic [1:0] fcnt_q, fcnt_d;

    assign rs_cand = id_rs_used_i && (id_rs_i != '0);
    assign rt_cand = id_rt_used_i && (id_rt_i != '0);

    assign ex_load_hit = ex_load_i &&
                         ((rs_cand && (id_rs_i == ex_rd_i)) || (rt_cand && (id_rt_i == ex_rd_i)));

    // Older loads still in flight past EX; shifts every cycle, stall or not.
    if (LOAD_LAT > 1) begin : gen_dl
        localparam int unsigned N = LOAD_LAT - 1;
        logic [N-1:0]     dl_valid_q;
        logic [REG_W-1:0] dl_addr_q [N];
        logic             hit;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                dl_valid_q <= '0;
            end else begin
                dl_valid_q[0] <= ex_load_i && (ex_rd_i != '0);
                for (int k = 1; k < N; k++) begin
                    dl_valid_q[k] <= dl_valid_q[k-1];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            dl_addr_q[0] <= ex_rd_i;
            for (int k = 1; k < N; k++) begin
                dl_addr_q[k] <= dl_addr_q[k-1];
            end
        end

        always_comb begin
            hit = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (dl_valid_q[k] && ((rs_cand && (id_rs_i == dl_addr_q[k])) ||
                                      (rt_cand && (id_rt_i == dl_addr_q[k])))) begin
                    hit = 1'b1;
                end
            end
        end

        assign dl_hit = hit;
    end else begin : gen_no_dl
        assign dl_hit = 1'b0;
    end

    assign load_hazard   = ex_load_hit || dl_hit;
    assign branch_hazard = id_branch_i && ex_regwrite_i && (ex_rd_i != '0) &&
                           ((rs_cand && (id_rs_i == ex_rd_i)) ||
                            (rt_cand && (id_rt_i == ex_rd_i)));
    assign hazard        = load_hazard || branch_hazard;
    assign redirect      = jump_i || branch_taken_i;

    always_comb begin
        stall_o     = 1'b0;
        flush_o     = FLUSH_NEXT;
        pc_hazard_o = 1'b0;
        fcnt_d      = fcnt_q;
        if (rst_i) begin
            fcnt_d = 2'b00;
        end else if (fcnt_q != 2'b00) begin
            // Wrong-path instruction in IF/ID: squash it and ignore its hazards/redirects.
            stall_o = 1'b1;
            flush_o = FLUSH_SQUASH;
            fcnt_d  = fcnt_q - 2'b01;
        end else if (hazard) begin
            stall_o     = 1'b1;
            flush_o     = FLUSH_HOLD;
            pc_hazard_o = 1'b1;
        end else if (redirect) begin
            stall_o = 1'b1;
            flush_o = FLUSH_SQUASH;
            fcnt_d  = FCNT_RELOAD;
        end
    end

    always_ff @(posedge clk_i) begin
        fcnt_q <= fcnt_d;
    end

`ifdef HAZARD_CTRL_STATS_EN
    logic             stall_evt, flush_evt;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    assign stall_evt = !rst_i && (fcnt_q == 2'b00) && hazard;
    assign flush_evt = !rst_i && ((fcnt_q != 2'b00) || (redirect && !hazard));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default instance (a) and LOAD_LAT=3/FLUSH_CYCLES=3/CNT_W=2 (b).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_rs_used, id_rt_used, id_branch, ex_load, ex_regwrite, jump, taken;

    logic        a_stall, a_pc, b_stall, b_pc;
    logic [1:0]  a_flush, b_flush;
    logic [15:0] a_scnt, a_fcnt;
    logic [1:0]  b_scnt, b_fcnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut_a (
        .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used), .id_branch_i(id_branch),
        .ex_rd_i(ex_rd), .ex_load_i(ex_load), .ex_regwrite_i(ex_regwrite), .jump_i(jump),
        .branch_taken_i(taken), .stall_o(a_stall), .flush_o(a_flush), .pc_hazard_o(a_pc),
        .stall_cnt_o(a_scnt), .flush_cnt_o(a_fcnt)
    );

    hazard_ctrl #(.LOAD_LAT(3), .FLUSH_CYCLES(3), .CNT_W(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used), .id_branch_i(id_branch),
        .ex_rd_i(ex_rd), .ex_load_i(ex_load), .ex_regwrite_i(ex_regwrite), .jump_i(jump),
        .branch_taken_i(taken), .stall_o(b_stall), .flush_o(b_flush), .pc_hazard_o(b_pc),
        .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt)
    );

    // Packed {stall, flush[1:0], pc_hazard}: 1001 stall, 1010 flush, 0100 next.
    wire [3:0] a_out = {a_stall, a_flush, a_pc};
    wire [3:0] b_out = {b_stall, b_flush, b_pc};

    task automatic clear_inputs();
        rst = 1'b0; id_rs = '0; id_rt = '0; ex_rd = '0;
        id_rs_used = 1'b0; id_rt_used = 1'b0; id_branch = 1'b0;
        ex_load = 1'b0; ex_regwrite = 1'b0; jump = 1'b0; taken = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_duts();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1; jump = 1'b1; ex_load = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_rs_used = 1'b1;
        @(negedge clk);
        tests++; if (a_out !== 4'b0100) begin fails++; $display("FAIL reset_ovr_a got %b exp 0100", a_out); end
        tests++; if (b_out !== 4'b0100) begin fails++; $display("FAIL reset_ovr_b got %b exp 0100", b_out); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        tests++; if (a_out !== 4'b0100) begin fails++; $display("FAIL reset_idle_a got %b exp 0100", a_out); end
        tests++; if ({a_scnt, a_fcnt, b_scnt, b_fcnt} !== 36'd0) begin
            fails++; $display("FAIL reset_cnt got %h exp 0", {a_scnt, a_fcnt, b_scnt, b_fcnt});
        end
        next_cycle();
    endtask

    task automatic test_load_lat1();
        reset_duts();
        ex_load = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_rs_used = 1'b1;
        @(negedge clk);
        tests++; if (a_out !== 4'b1001) begin fails++; $display("FAIL lat1_c1_a got %b exp 1001", a_out); end
        next_cycle();
        ex_load = 1'b0; ex_rd = 5'd0;
        @(negedge clk);
        tests++; if (a_out !== 4'b0100) begin fails++; $display("FAIL lat1_c2_a got %b exp 0100", a_out); end
        tests++; if (b_out !== 4'b1001) begin fails++; $display("FAIL lat1_c2_b got %b exp 1001", b_out); end
        next_cycle();
    endtask

    task automatic test_load_lat3();
        logic [3:0] exp_b [4];
        exp_b[0] = 4'b1001; exp_b[1] = 4'b1001; exp_b[2] = 4'b1001; exp_b[3] = 4'b0100;
        reset_duts();
        ex_load = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_rt_used = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++; if (b_out !== exp_b[c]) begin
                fails++; $display("FAIL lat3_c%0d_b got %b exp %b", c + 1, b_out, exp_b[c]);
            end
            next_cycle();
            ex_load = 1'b0; ex_rd = 5'd0;
        end
    endtask

    task automatic test_reg0();
        reset_duts();
        ex_load = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_rs_used = 1'b1;
        @(negedge clk);
        tests++; if (a_out !== 4'b0100) begin fails++; $display("FAIL reg0_a got %b exp 0100", a_out); end
        next_cycle();
        ex_rd = 5'd5; id_rt = 5'd5; id_rt_used = 1'b0;
        @(negedge clk);
        tests++; if (a_out !== 4'b0100) begin fails++; $display("FAIL unused_rt_a got %b exp 0100", a_out); end
        tests++; if (b_out !== 4'b0100) begin fails++; $display("FAIL unused_rt_b got %b exp 0100", b_out); end
        next_cycle();
        ex_load = 1'b0; ex_rd = 5'd0;
        @(negedge clk);
        tests++; if (b_out !== 4'b0100) begin fails++; $display("FAIL unused_rt_dl_b got %b exp 0100", b_out); end
        next_cycle();
        // Non-load producer with a non-branch consumer is forwarded, no stall.
        ex_regwrite = 1'b1; ex_rd = 5'd6; id_rs = 5'd6; id_rt_used = 1'b0;
        @(negedge clk);
        tests++; if (a_out !== 4'b0100) begin fails++; $display("FAIL alu_fwd_a got %b exp 0100", a_out); end
        next_cycle();
    endtask

    task automatic test_jump();
        logic [1:0] exp_bf;
        reset_duts();
        jump = 1'b1;
        @(negedge clk);
        tests++; if (b_out !== 4'b1010) begin fails++; $display("FAIL jmp_c1_b got %b exp 1010", b_out); end
        tests++; if (a_out !== 4'b1010) begin fails++; $display("FAIL jmp_c1_a got %b exp 1010", a_out); end
        next_cycle();
        @(negedge clk);
        tests++; if (b_out !== 4'b1010) begin fails++; $display("FAIL jmp_c2_b got %b exp 1010", b_out); end
        tests++; if (a_out !== 4'b1010) begin fails++; $display("FAIL jmp_c2_a got %b exp 1010", a_out); end
        next_cycle();
        jump = 1'b0; ex_load = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_rs_used = 1'b1;
        @(negedge clk);
        tests++; if (b_out !== 4'b1010) begin fails++; $display("FAIL jmp_c3_supp_b got %b exp 1010", b_out); end
        tests++; if (a_out !== 4'b1001) begin fails++; $display("FAIL jmp_c3_a got %b exp 1001", a_out); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        tests++; if (b_out !== 4'b0100) begin fails++; $display("FAIL jmp_c4_b got %b exp 0100", b_out); end
`ifdef HAZARD_CTRL_STATS_EN
        tests++; if ({a_scnt, a_fcnt, b_scnt, b_fcnt} !== {16'd1, 16'd2, 2'd0, 2'd3}) begin
            fails++; $display("FAIL jmp_stats got %0d %0d %0d %0d exp 1 2 0 3",
                              a_scnt, a_fcnt, b_scnt, b_fcnt);
        end
        exp_bf = 2'd3;
`else
        tests++; if ({a_scnt, a_fcnt, b_scnt, b_fcnt} !== 36'd0) begin
            fails++; $display("FAIL jmp_stats_off got %h exp 0", {a_scnt, a_fcnt, b_scnt, b_fcnt});
        end
        exp_bf = 2'd0;
`endif
        next_cycle();
        jump = 1'b1;
        next_cycle();
        jump = 1'b0;
        @(negedge clk);
        tests++; if (b_fcnt !== exp_bf) begin fails++; $display("FAIL stats_sat_b got %0d exp %0d", b_fcnt, exp_bf); end
        next_cycle();
    endtask

    task automatic test_branch();
        reset_duts();
        id_branch = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd4; id_rs = 5'd4; id_rs_used = 1'b1;
        taken = 1'b1;
        @(negedge clk);
        tests++; if (a_out !== 4'b1001) begin fails++; $display("FAIL br_c1_a got %b exp 1001", a_out); end
        tests++; if (b_out !== 4'b1001) begin fails++; $display("FAIL br_c1_b got %b exp 1001", b_out); end
        next_cycle();
        ex_regwrite = 1'b0; ex_rd = 5'd0;
        @(negedge clk);
        tests++; if (a_out !== 4'b1010) begin fails++; $display("FAIL br_c2_a got %b exp 1010", a_out); end
        tests++; if (b_out !== 4'b1010) begin fails++; $display("FAIL br_c2_b got %b exp 1010", b_out); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        tests++; if (a_out !== 4'b0100) begin fails++; $display("FAIL br_c3_a got %b exp 0100", a_out); end
        tests++; if (b_out !== 4'b1010) begin fails++; $display("FAIL br_c3_b got %b exp 1010", b_out); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        reset_duts();
        jump = 1'b1;
        next_cycle();
        jump = 1'b0; rst = 1'b1;
        @(negedge clk);
        tests++; if (b_out !== 4'b0100) begin fails++; $display("FAIL rst_flush_b got %b exp 0100", b_out); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        tests++; if (b_out !== 4'b0100) begin fails++; $display("FAIL post_rst_flush_b got %b exp 0100", b_out); end
        tests++; if ({b_scnt, b_fcnt} !== 4'd0) begin
            fails++; $display("FAIL post_rst_cnt_b got %0d %0d exp 0 0", b_scnt, b_fcnt);
        end
        next_cycle();
        ex_load = 1'b1; ex_rd = 5'd9; id_rs = 5'd9; id_rs_used = 1'b1;
        next_cycle();
        ex_load = 1'b0; ex_rd = 5'd0; rst = 1'b1;
        @(negedge clk);
        tests++; if (b_out !== 4'b0100) begin fails++; $display("FAIL rst_stall_b got %b exp 0100", b_out); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        tests++; if (b_out !== 4'b0100) begin fails++; $display("FAIL post_rst_stall_b got %b exp 0100", b_out); end
        next_cycle();
    endtask

    initial begin
        clear_inputs();
        next_cycle();
        test_reset();
        test_load_lat1();
        test_load_lat3();
        test_reg0();
        test_jump();
        test_branch();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter REG_W, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter LOAD_LAT, default 1, range 1..3, meaning cycles after a load enters EX before its data is forwardable.
REQ-003 The block SHALL have parameter FLUSH_CYCLES, default 1, range 1..3, meaning cycles the front end is flushed per redirect.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning statistics counter width.
REQ-005 The block SHALL have a single clock and a synchronous, active-high reset, with these ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous active-high reset
- id_rs_i / id_rt_i  in  REG_W  source registers of the IF/ID instruction
- id_rs_used_i / id_rt_used_i  in  1  source actually read
- id_branch_i  in  1  ID instruction is a branch compared in ID
- ex_rd_i  in  REG_W  destination of the ID/EX instruction
- ex_load_i  in  1  ID/EX instruction is a load
- ex_regwrite_i  in  1  ID/EX instruction writes a register
- jump_i  in  1  jump resolved in ID
- branch_taken_i  in  1  taken branch resolved in ID
- stall_o  out  1  hold IF/ID, insert bubble into ID/EX
- flush_o  out  2  00 stall, 01 flush, 10 new instruction
- pc_hazard_o  out  1  hold PC
- stall_cnt_o / flush_cnt_o  out  CNT_W  statistics

Function
REQ-006 The block SHALL treat a source as a hazard candidate only when its used flag is 1 and its address is nonzero; register 0 SHALL never cause a stall.
REQ-007 The block SHALL keep a pending-load delay line of LOAD_LAT-1 entries (valid + REG_W address); each cycle entry 0 loads {ex_load_i && ex_rd_i!=0, ex_rd_i}, entry k loads entry k-1; for LOAD_LAT=1 the line is empty.
REQ-008 The delay line SHALL shift every cycle, including stall cycles.
REQ-009 load_hazard SHALL be 1 when a candidate source equals ex_rd_i with ex_load_i=1, or equals the address of any valid delay-line entry.
REQ-010 branch_hazard SHALL be 1 when id_branch_i=1, ex_regwrite_i=1, ex_rd_i!=0 and a candidate source equals ex_rd_i.
REQ-011 A 2-bit flush counter fcnt SHALL exist; when fcnt!=0 the IF/ID instruction is squashed and hazard detection SHALL be suppressed.
REQ-012 Priority per cycle: (1) fcnt!=0 -> stall_o=1, flush_o=01, pc_hazard_o=0, fcnt decrements; (2) load_hazard or branch_hazard -> stall_o=1, flush_o=00, pc_hazard_o=1; (3) jump_i or branch_taken_i -> stall_o=1, flush_o=01, pc_hazard_o=0, fcnt<=FLUSH_CYCLES-1; (4) otherwise stall_o=0, flush_o=10, pc_hazard_o=0.
REQ-013 A redirect arriving while fcnt!=0 SHALL be ignored (wrong-path instruction).
REQ-014 A redirect simultaneous with a hazard SHALL be deferred; it re-evaluates once the hazard clears.
REQ-015 Outputs SHALL be combinational from inputs and registered state; zero-latency decision.
REQ-016 flush_o SHALL never take value 11.

Reset
REQ-017 While rst_i=1 at a clock edge, the delay line valids, fcnt and statistics counters SHALL clear to 0.
REQ-018 In a cycle with rst_i=1, outputs SHALL be stall_o=0, flush_o=10, pc_hazard_o=0, overriding all other logic.
REQ-019 Reset asserted mid-flush or mid-stall SHALL abort it; the first post-reset cycle follows REQ-012 with empty state.

Configuration
REQ-020 When macro HAZARD_CTRL_STATS_EN is defined, stall_cnt_o SHALL increment on each priority-(2) cycle and flush_cnt_o on each priority-(1) or (3) cycle, both saturating at 2^CNT_W-1.
REQ-021 When HAZARD_CTRL_STATS_EN is undefined, no counter registers SHALL exist and stall_cnt_o, flush_cnt_o SHALL be constant 0.

Verification
REQ-022 LOAD_LAT=1: ex_load_i=1, ex_rd_i=8, id_rs_i=8 used -> one cycle stall_o=1, flush_o=00, pc_hazard_o=1; next cycle (ex_load_i=0) flush_o=10.
REQ-023 LOAD_LAT=3: load to r9 in EX, dependent ID read of r9 -> exactly 3 consecutive stall cycles, then flush_o=10.
REQ-024 ex_load_i=1, ex_rd_i=0, id_rs_i=0 used -> no stall; id_rt_i=5 with id_rt_used_i=0 and ex_rd_i=5 load -> no stall.
REQ-025 FLUSH_CYCLES=3: jump_i=1 for one cycle -> flush_o=01 for 3 cycles; second jump_i in cycle 2 ignored; cycle 4 flush_o=10.
REQ-026 id_branch_i=1, ex_regwrite_i=1, ex_rd_i=4, id_rs_i=4, branch_taken_i=1 -> cycle 1 flush_o=00; cycle 2 (no hazard, taken) flush_o=01.
REQ-027 rst_i=1 in second cycle of a 3-cycle flush -> that cycle flush_o=10; with HAZARD_CTRL_STATS_EN defined, counters read 0 after reset.
